// File: rtl/dyn_mem_responder.sv
// Memory-side responder for a single shared dynamic memory port.
// Accepts level-held read/write requests, waits a fixed latency, then
// returns a one-cycle done pulse. Every output comes straight from a flop.
module dyn_mem_responder #(
    parameter int unsigned WIDTH         = 32,
    parameter int unsigned SIZE          = 16,
    parameter int unsigned IDX_SIZE      = 4,
    parameter int unsigned READ_LATENCY  = 2,
    parameter int unsigned WRITE_LATENCY = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [IDX_SIZE-1:0] mem_addr,
    input  logic                mem_read_en,
    input  logic                mem_write_en,
    input  logic [WIDTH-1:0]    mem_in,
    output logic [WIDTH-1:0]    mem_out,
    output logic                mem_read_done,
    output logic                mem_write_done
);

    localparam int unsigned AW = (SIZE > 1) ? $clog2(SIZE) : 1;
    // Busy-state reload values; a latency of 1 skips the busy state entirely.
    localparam logic [7:0] RdReload = (READ_LATENCY >= 2) ? 8'(READ_LATENCY - 2) : 8'd0;
    localparam logic [7:0] WrReload = (WRITE_LATENCY >= 2) ? 8'(WRITE_LATENCY - 2) : 8'd0;

    if (READ_LATENCY < 1 || READ_LATENCY > 255) begin : g_bad_rd_lat
        $error("dyn_mem_responder: READ_LATENCY must be in 1..255");
    end
    if (WRITE_LATENCY < 1 || WRITE_LATENCY > 255) begin : g_bad_wr_lat
        $error("dyn_mem_responder: WRITE_LATENCY must be in 1..255");
    end
    if (SIZE > (2 ** IDX_SIZE)) begin : g_bad_size
        $error("dyn_mem_responder: SIZE exceeds the address space of IDX_SIZE");
    end

    typedef enum logic [2:0] {StIdle, StRBusy, StWBusy, StRDone, StWDone} state_e;

    state_e              state_q, state_d;
    logic [7:0]          cnt_q, cnt_d;
    logic [IDX_SIZE-1:0] addr_q, addr_d;
    logic [WIDTH-1:0]    data_q, data_d;
    logic [WIDTH-1:0]    out_q, out_d;
    logic                rd_done_q, wr_done_q;

    logic                enter_rdone, enter_wdone;
    logic [IDX_SIZE-1:0] acc_addr;
    logic [WIDTH-1:0]    acc_data;
    logic                in_range;
    logic                mem_we;

    logic [WIDTH-1:0]    mem_q [SIZE];

    // Next-state, counter and read-data selection.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        data_d      = data_q;
        enter_rdone = 1'b0;
        enter_wdone = 1'b0;
        // With latency 1 the access completes on the accepting edge, so the
        // live inputs stand in for the not-yet-latched copies.
        acc_addr    = addr_q;
        acc_data    = data_q;
        unique case (state_q)
            StIdle: begin
                if (mem_read_en) begin
                    addr_d   = mem_addr;
                    acc_addr = mem_addr;
                    if (READ_LATENCY == 1) begin
                        state_d     = StRDone;
                        enter_rdone = 1'b1;
                    end else begin
                        state_d = StRBusy;
                        cnt_d   = RdReload;
                    end
                end else if (mem_write_en) begin
                    addr_d   = mem_addr;
                    data_d   = mem_in;
                    acc_addr = mem_addr;
                    acc_data = mem_in;
                    if (WRITE_LATENCY == 1) begin
                        state_d     = StWDone;
                        enter_wdone = 1'b1;
                    end else begin
                        state_d = StWBusy;
                        cnt_d   = WrReload;
                    end
                end
            end
            StRBusy: begin
                if (cnt_q == 8'd0) begin
                    state_d     = StRDone;
                    enter_rdone = 1'b1;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            StWBusy: begin
                if (cnt_q == 8'd0) begin
                    state_d     = StWDone;
                    enter_wdone = 1'b1;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            StRDone, StWDone: state_d = StIdle;
            default:          state_d = StIdle;
        endcase

        in_range = (32'(acc_addr) < SIZE);
        mem_we   = enter_wdone && in_range;
        out_d    = out_q;
        if (enter_rdone) begin
            out_d = in_range ? mem_q[acc_addr[AW-1:0]] : '0;
        end
    end

    // Control and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            out_q     <= '0;
            rd_done_q <= 1'b0;
            wr_done_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            out_q     <= out_d;
            rd_done_q <= enter_rdone;
            wr_done_q <= enter_wdone;
        end
    end

    // Storage array: not cleared by reset; a reset edge suppresses the commit.
    always_ff @(posedge clk) begin
        if (!reset && mem_we) begin
            mem_q[acc_addr[AW-1:0]] <= acc_data;
        end
    end

    assign mem_out        = out_q;
    assign mem_read_done  = rd_done_q;
    assign mem_write_done = wr_done_q;

endmodule

// File: tb/tb_dyn_mem_responder.sv
// Directed self-checking bench for dyn_mem_responder
// (READ_LATENCY=3, WRITE_LATENCY=2, SIZE=16, IDX_SIZE=5).
module tb_dyn_mem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  mem_addr;
    logic        mem_read_en;
    logic        mem_write_en;
    logic [31:0] mem_in;
    logic [31:0] mem_out;
    logic        mem_read_done;
    logic        mem_write_done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dyn_mem_responder #(
        .WIDTH(32), .SIZE(16), .IDX_SIZE(5), .READ_LATENCY(3), .WRITE_LATENCY(2)
    ) dut (
        .clk(clk), .reset(reset), .mem_addr(mem_addr), .mem_read_en(mem_read_en),
        .mem_write_en(mem_write_en), .mem_in(mem_in), .mem_out(mem_out),
        .mem_read_done(mem_read_done), .mem_write_done(mem_write_done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue a write and hold it until done (bounded); returns latency in cycles,
    // the done level one cycle after the pulse, and whether read_done ever rose.
    task automatic do_write(input logic [4:0] a, input logic [31:0] d, output int lat,
                            output logic tail, output logic other);
        mem_addr = a; mem_in = d; mem_write_en = 1'b1;
        lat = 0; other = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (mem_read_done) other = 1'b1;
            if (mem_write_done) begin
                lat = i;
                break;
            end
        end
        mem_write_en = 1'b0;
        tick();
        tail = mem_write_done;
    endtask

    task automatic do_read(input logic [4:0] a, output logic [31:0] d, output int lat,
                           output logic tail, output logic other);
        mem_addr = a; mem_read_en = 1'b1;
        lat = 0; other = 1'b0; d = 'x;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (mem_write_done) other = 1'b1;
            if (mem_read_done) begin
                lat = i;
                d   = mem_out;
                break;
            end
        end
        mem_read_en = 1'b0;
        tick();
        tail = mem_read_done;
    endtask

    task automatic test_reset();
        reset = 1'b1; mem_addr = '0; mem_read_en = 1'b0; mem_write_en = 1'b0; mem_in = '0;
        repeat (3) tick();
        checks++;
        if (mem_out !== 32'h0) begin
            errors++; $display("FAIL reset_mem_out: got %h expected %h", mem_out, 32'h0);
        end
        checks++;
        if (mem_read_done !== 1'b0 || mem_write_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_done: got rd=%b wr=%b expected 0 0",
                     mem_read_done, mem_write_done);
        end
        reset = 1'b0;
        tick();
    endtask

    // Known contents for the addresses the later scenarios touch.
    task automatic test_prime();
        logic [4:0]  addrs [6] = '{5'd3, 5'd4, 5'd7, 5'd9, 5'd15, 5'd5};
        logic [31:0] vals  [6] = '{32'h33, 32'h44, 32'h77, 32'h99, 32'hF0F0, 32'h55};
        int lat; logic tail, other;
        for (int i = 0; i < 6; i++) begin
            do_write(addrs[i], vals[i], lat, tail, other);
            checks++;
            if (lat != 2 || tail !== 1'b0 || other !== 1'b0) begin
                errors++;
                $display("FAIL prime_write[%0d]: got lat=%0d tail=%b other=%b expected 2 0 0",
                         i, lat, tail, other);
            end
        end
    endtask

    task automatic test_write_read();
        int lat; logic tail, other; logic [31:0] d;
        do_write(5'd5, 32'hDEADBEEF, lat, tail, other);
        checks++;
        if (lat != 2 || tail !== 1'b0 || other !== 1'b0) begin
            errors++;
            $display("FAIL wr_timing: got lat=%0d tail=%b other=%b expected 2 0 0",
                     lat, tail, other);
        end
        do_read(5'd5, d, lat, tail, other);
        checks++;
        if (lat != 3 || tail !== 1'b0 || other !== 1'b0) begin
            errors++;
            $display("FAIL rd_timing: got lat=%0d tail=%b other=%b expected 3 0 0",
                     lat, tail, other);
        end
        checks++;
        if (d !== 32'hDEADBEEF) begin
            errors++; $display("FAIL rd_after_wr: got %h expected %h", d, 32'hDEADBEEF);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (mem_out !== 32'hDEADBEEF || mem_read_done !== 1'b0) begin
                errors++;
                $display("FAIL rd_hold[%0d]: got %h/%b expected %h/0",
                         i, mem_out, mem_read_done, 32'hDEADBEEF);
            end
        end
    endtask

    task automatic test_priority();
        int lat; logic tail, other; logic [31:0] d;
        mem_addr = 5'd3; mem_in = 32'h11; mem_read_en = 1'b1; mem_write_en = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            checks++;
            if (mem_read_done !== (k == 3) || mem_write_done !== (k == 6)) begin
                errors++;
                $display("FAIL prio_done[k=%0d]: got rd=%b wr=%b expected %b %b",
                         k, mem_read_done, mem_write_done, k == 3, k == 6);
            end
            if (k == 3) begin
                checks++;
                if (mem_out !== 32'h33) begin
                    errors++; $display("FAIL prio_old_data: got %h expected %h", mem_out, 32'h33);
                end
                mem_read_en = 1'b0;
            end
            if (k == 6) mem_write_en = 1'b0;
        end
        do_read(5'd3, d, lat, tail, other);
        checks++;
        if (d !== 32'h11 || lat != 3) begin
            errors++; $display("FAIL prio_reread: got %h lat=%0d expected %h lat=3", d, lat, 32'h11);
        end
    endtask

    task automatic test_addr_hold();
        int lat; logic tail, other; logic [31:0] d;
        mem_addr = 5'd5; mem_in = 32'hCAFEF00D; mem_write_en = 1'b1;
        tick();
        mem_addr = 5'd7; mem_in = 32'h0BADBEEF;
        tick();
        checks++;
        if (mem_write_done !== 1'b1) begin
            errors++; $display("FAIL hold_done: got %b expected 1", mem_write_done);
        end
        mem_write_en = 1'b0;
        tick();
        do_read(5'd5, d, lat, tail, other);
        checks++;
        if (d !== 32'hCAFEF00D) begin
            errors++; $display("FAIL hold_addr5: got %h expected %h", d, 32'hCAFEF00D);
        end
        do_read(5'd7, d, lat, tail, other);
        checks++;
        if (d !== 32'h77) begin
            errors++; $display("FAIL hold_addr7: got %h expected %h", d, 32'h77);
        end
    endtask

    task automatic test_reset_mid();
        int lat; logic tail, other; logic [31:0] d;
        mem_addr = 5'd5; mem_read_en = 1'b1;
        tick();
        reset = 1'b1; mem_read_en = 1'b0;
        tick();
        checks++;
        if (mem_out !== 32'h0 || mem_read_done !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_rd: got %h/%b expected 0/0", mem_out, mem_read_done);
        end
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (mem_read_done !== 1'b0) begin
                errors++; $display("FAIL rstmid_no_done[%0d]: got %b expected 0", i, mem_read_done);
            end
        end
        do_read(5'd5, d, lat, tail, other);
        checks++;
        if (d !== 32'hCAFEF00D || lat != 3) begin
            errors++;
            $display("FAIL rstmid_reread: got %h lat=%0d expected %h lat=3", d, lat, 32'hCAFEF00D);
        end
        // Write aborted by reset must not commit.
        mem_addr = 5'd9; mem_in = 32'hBAD0BAD0; mem_write_en = 1'b1;
        tick();
        reset = 1'b1; mem_write_en = 1'b0;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (mem_write_done !== 1'b0) begin
                errors++; $display("FAIL rstmid_no_wdone[%0d]: got %b expected 0", i, mem_write_done);
            end
        end
        do_read(5'd9, d, lat, tail, other);
        checks++;
        if (d !== 32'h99) begin
            errors++; $display("FAIL rstmid_wr_dropped: got %h expected %h", d, 32'h99);
        end
    endtask

    task automatic test_back_to_back();
        mem_addr = 5'd15; mem_read_en = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            tick();
            checks++;
            if (mem_read_done !== (k == 3 || k == 7)) begin
                errors++;
                $display("FAIL b2b_done[k=%0d]: got %b expected %b",
                         k, mem_read_done, k == 3 || k == 7);
            end
            if (k == 5) mem_read_en = 1'b0;
        end
        checks++;
        if (mem_out !== 32'hF0F0) begin
            errors++; $display("FAIL b2b_data: got %h expected %h", mem_out, 32'hF0F0);
        end
    endtask

    task automatic test_out_of_range();
        int lat; logic tail, other; logic [31:0] d;
        do_read(5'd15, d, lat, tail, other);
        checks++;
        if (d !== 32'hF0F0 || lat != 3) begin
            errors++; $display("FAIL oor_rd15: got %h lat=%0d expected %h lat=3", d, lat, 32'hF0F0);
        end
        do_write(5'd20, 32'h12345678, lat, tail, other);
        checks++;
        if (lat != 2 || tail !== 1'b0 || other !== 1'b0) begin
            errors++;
            $display("FAIL oor_wr_timing: got lat=%0d tail=%b other=%b expected 2 0 0",
                     lat, tail, other);
        end
        do_read(5'd20, d, lat, tail, other);
        checks++;
        if (d !== 32'h0 || lat != 3 || tail !== 1'b0) begin
            errors++;
            $display("FAIL oor_rd20: got %h lat=%0d tail=%b expected 0 lat=3 tail=0", d, lat, tail);
        end
        do_read(5'd4, d, lat, tail, other);
        checks++;
        if (d !== 32'h44) begin
            errors++; $display("FAIL oor_no_alias: got %h expected %h", d, 32'h44);
        end
    endtask

    initial begin
        test_reset();
        test_prime();
        test_write_read();
        test_priority();
        test_addr_hold();
        test_reset_mid();
        test_back_to_back();
        test_out_of_range();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
